stream_mux_arb: RTL and testbench

- Parametrised successor of the combinational 16:1 byte mux: N_CH channels of WIDTH bits, each with a valid/ready handshake, merged onto one registered output stream.
- Channel choice is either externally selected (fixed mode) or round-robin arbitrated among valid channels.
- Sits between the datapath sources (register file ports, ALU result, memory read data) and the single consumer that previously took a raw mux output.
- Adds back-pressure, a one-deep output register and source tagging.

---
 rtl/stream_mux_arb_pkg.sv | 21 ++
 rtl/stream_mux_arb_rr_arbiter.sv | 41 ++++
 rtl/stream_mux_arb.sv | 148 ++++++++++++++
 tb/tb_stream_mux_arb.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_mux_arb_pkg.sv
// Shared constants and helpers for the stream_mux_arb channel merger.
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Index after idx in a ring of n entries.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    if (idx + 32'd1 >= n) begin
      return 32'd0;
    end else begin
      return idx + 32'd1;
    end
  endfunction

  // Even parity (XOR of all bits); callers zero-extend narrower data.
  function automatic logic even_parity(input logic [63:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/stream_mux_arb_rr_arbiter.sv
// Combinational round-robin arbiter: the first request after 'last', wrapping
// around the ring. The pointer register lives in the caller.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int N_CH  = 16,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] last,
  output logic [SEL_W-1:0] grant,
  output logic             any
);

  logic [SEL_W-1:0] start;

  assign start = SEL_W'(wrap_inc(32'(last), N_CH));

  // Two passes: first the channels at or above the start point, then the ones below it.
  always_comb begin
    grant = '0;
    any   = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (!any && req[i] && (SEL_W'(i) >= start)) begin
        grant = SEL_W'(i);
        any   = 1'b1;
      end else begin
        any   = any;
      end
    end
    for (int i = 0; i < N_CH; i++) begin
      if (!any && req[i] && (SEL_W'(i) < start)) begin
        grant = SEL_W'(i);
        any   = 1'b1;
      end else begin
        any   = any;
      end
    end
  end

endmodule

// File: rtl/stream_mux_arb.sv
// N_CH-to-1 valid/ready stream merger with fixed or round-robin selection and a
// one-deep registered output. Define STREAM_MUX_PARITY_EN to add the OutParity port.
module stream_mux_arb
  import mux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N_CH  = 16,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [N_CH*WIDTH-1:0] InData,
  input  logic [N_CH-1:0]       InValid,
  output logic [N_CH-1:0]       InReady,
  input  logic                  Mode,
  input  logic [SEL_W-1:0]      Sel,
  output logic [WIDTH-1:0]      OutData,
  output logic                  OutValid,
  input  logic                  OutReady,
  output logic [SEL_W-1:0]      OutChan,
  output logic                  SelErr
`ifdef STREAM_MUX_PARITY_EN
  ,
  output logic                  OutParity
`endif
);

  logic [WIDTH-1:0] out_data_r;
  logic [SEL_W-1:0] out_chan_r;
  logic             out_valid_r;
  logic             sel_err_r;
  logic [SEL_W-1:0] last_r;

  logic             load_s;
  logic             sel_hit_s;
  logic             fix_valid_s;
  logic [SEL_W-1:0] rr_grant_s;
  logic             rr_any_s;
  logic [SEL_W-1:0] grant_s;
  logic             granted_s;
  logic             xfer_s;
  logic             sel_err_s;
  logic [WIDTH-1:0] grant_data_s;

  rr_arbiter #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W)
  ) u_rr (
    .req   (InValid),
    .last  (last_r),
    .grant (rr_grant_s),
    .any   (rr_any_s)
  );

  assign load_s = !out_valid_r || OutReady;

  // Decode Sel by matching, so an out-of-range Sel never indexes past InValid.
  always_comb begin
    sel_hit_s   = 1'b0;
    fix_valid_s = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (Sel == SEL_W'(i)) begin
        sel_hit_s   = 1'b1;
        fix_valid_s = InValid[i];
      end else begin
        sel_hit_s   = sel_hit_s;
      end
    end
  end

  // Grant selection for the current mode.
  always_comb begin
    if (Mode == MODE_RR) begin
      grant_s   = rr_grant_s;
      granted_s = rr_any_s;
    end else begin
      grant_s   = Sel;
      granted_s = sel_hit_s && fix_valid_s;
    end
  end

  assign xfer_s    = !Reset && load_s && granted_s;
  assign sel_err_s = (Mode == MODE_FIXED) && !sel_hit_s && (|InValid);

  // Ready decode and data mux for the granted channel.
  always_comb begin
    InReady      = '0;
    grant_data_s = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant_s == SEL_W'(i)) begin
        InReady[i]   = xfer_s;
        grant_data_s = InData[i*WIDTH +: WIDTH];
      end else begin
        InReady[i]   = 1'b0;
      end
    end
  end

  // Output register, round-robin pointer and Sel error flag.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      out_data_r  <= '0;
      out_chan_r  <= '0;
      out_valid_r <= 1'b0;
      sel_err_r   <= 1'b0;
      last_r      <= SEL_W'(N_CH - 1);
    end else begin
      sel_err_r <= sel_err_s;
      if (xfer_s) begin
        out_data_r  <= grant_data_s;
        out_chan_r  <= grant_s;
        out_valid_r <= 1'b1;
        if (Mode == MODE_RR) begin
          last_r <= grant_s;
        end else begin
          last_r <= last_r;
        end
      end else if (load_s) begin
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end
    end
  end

`ifdef STREAM_MUX_PARITY_EN
  logic parity_r;

  // Parity travels with the data beat.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      parity_r <= 1'b0;
    end else if (xfer_s) begin
      parity_r <= even_parity(64'(grant_data_s));
    end else begin
      parity_r <= parity_r;
    end
  end

  assign OutParity = parity_r;
`endif

  assign OutData  = out_data_r;
  assign OutChan  = out_chan_r;
  assign OutValid = out_valid_r;
  assign SelErr   = sel_err_r;

endmodule

// File: tb/tb_stream_mux_arb.sv
// Scoreboard bench for stream_mux_arb: a 16-channel instance driven by directed and
// random traffic against a reference model, plus a 12-channel instance for SelErr.
module tb_stream_mux_arb;
  import mux_pkg::*;

  localparam int W   = 8;
  localparam int N   = 16;
  localparam int SW  = 4;
  localparam int N12 = 12;

  typedef struct packed {
    logic [SW-1:0] chan;
    logic [W-1:0]  data;
  } beat_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid, in_ready;
  logic           mode, out_valid, out_ready, sel_err;
  logic [SW-1:0]  sel, out_chan;
  logic [W-1:0]   out_data;

  logic [N12*W-1:0] d12_in_data;
  logic [N12-1:0]   d12_in_valid, d12_in_ready;
  logic             d12_mode, d12_out_valid, d12_out_ready, d12_sel_err;
  logic [SW-1:0]    d12_sel, d12_out_chan;
  logic [W-1:0]     d12_out_data;

`ifdef STREAM_MUX_PARITY_EN
  logic out_parity, d12_out_parity;
`endif

  stream_mux_arb #(.WIDTH(W), .N_CH(N)) u_dut (
    .Clk(clk), .Reset(reset), .InData(in_data), .InValid(in_valid), .InReady(in_ready),
    .Mode(mode), .Sel(sel), .OutData(out_data), .OutValid(out_valid),
    .OutReady(out_ready), .OutChan(out_chan), .SelErr(sel_err)
`ifdef STREAM_MUX_PARITY_EN
    , .OutParity(out_parity)
`endif
  );

  stream_mux_arb #(.WIDTH(W), .N_CH(N12)) u_dut12 (
    .Clk(clk), .Reset(reset), .InData(d12_in_data), .InValid(d12_in_valid),
    .InReady(d12_in_ready), .Mode(d12_mode), .Sel(d12_sel), .OutData(d12_out_data),
    .OutValid(d12_out_valid), .OutReady(d12_out_ready), .OutChan(d12_out_chan),
    .SelErr(d12_sel_err)
`ifdef STREAM_MUX_PARITY_EN
    , .OutParity(d12_out_parity)
`endif
  );

  int    n_vec = 0;
  int    n_err = 0;
  beat_t sb[$];
  logic  m_valid;
  int    m_last;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic apply_reset();
    reset        = 1'b1;
    in_valid     = '1;
    in_data      = {$urandom, $urandom, $urandom, $urandom};
    mode         = 1'b1;
    sel          = 4'd7;
    out_ready    = 1'b0;
    d12_in_valid = '0;
    d12_in_data  = '0;
    d12_mode     = 1'b0;
    d12_sel      = 4'd0;
    d12_out_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      check_val("rst_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      @(negedge clk);
      #1;
      check_val("rst_out_valid", 32'(out_valid), 32'd0);
      check_val("rst_out_data", 32'(out_data), 32'd0);
      check_val("rst_out_chan", 32'(out_chan), 32'd0);
      check_val("rst_sel_err", 32'(sel_err), 32'd0);
    end
    reset   = 1'b0;
    m_valid = 1'b0;
    m_last  = N - 1;
    sb.delete();
  endtask

  // One clock of the 16-channel DUT: check registered state and ready, advance the model.
  task automatic step();
    bit             gnt;
    bit             load;
    int             g;
    logic [N-1:0]   exp_rdy;
    beat_t          b;
    #1;
    check_val("out_valid", 32'(out_valid), 32'(m_valid));
    check_val("sel_err", 32'(sel_err), 32'd0);
    if (m_valid) begin
      if (sb.size() == 0) begin
        check_val("sb_underflow", 32'd1, 32'd0);
      end else begin
        check_val("out_data", 32'(out_data), 32'(sb[0].data));
        check_val("out_chan", 32'(out_chan), 32'(sb[0].chan));
`ifdef STREAM_MUX_PARITY_EN
        check_val("out_parity", 32'(out_parity), 32'(^sb[0].data));
`endif
      end
    end
    load = !m_valid || out_ready;
    gnt  = 1'b0;
    g    = 0;
    if (mode == MODE_FIXED) begin
      g   = int'(sel);
      gnt = in_valid[sel];
    end else begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last + k) % N;
        if (!gnt && in_valid[c]) begin
          gnt = 1'b1;
          g   = c;
        end
      end
    end
    exp_rdy = '0;
    if (load && gnt) exp_rdy[g] = 1'b1;
    check_val("in_ready", 32'(in_ready), 32'(exp_rdy));
    if (m_valid && out_ready && sb.size() > 0) void'(sb.pop_front());
    if (load && gnt) begin
      b.chan = SW'(g);
      b.data = in_data[g*W +: W];
      sb.push_back(b);
      if (mode == MODE_RR) m_last = g;
    end
    if (load) m_valid = gnt;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    apply_reset();

    // First round-robin grants after reset, all channels valid: 0, 1, 2.
    mode = MODE_RR; out_ready = 1'b1; in_valid = '1;
    for (int i = 0; i < 3; i++) step();
    check_val("rr_first_chan", 32'(out_chan), 32'd2);

    // Fixed select of channel 5.
    mode = MODE_FIXED; sel = 4'd5; in_valid = 16'h0020;
    in_data = '0; in_data[5*W +: W] = 8'hA5;
    step();
    in_valid = '0;
    step();
    step();

    // Round-robin over channels 0, 1, 15 from a fresh pointer.
    apply_reset();
    mode = MODE_RR; out_ready = 1'b1; in_valid = 16'h8003;
    for (int i = 0; i < 7; i++) begin
      in_data = {$urandom, $urandom, $urandom, $urandom};
      step();
    end
    in_valid = '0;
    step();
    step();

    // Back-pressure on channel 2, then simultaneous pop and push.
    mode = MODE_FIXED; sel = 4'd2; in_valid = 16'h0004; out_ready = 1'b0;
    in_data = '0; in_data[2*W +: W] = 8'h3C;
    step();
    for (int i = 0; i < 4; i++) step();
    check_val("bp_hold_data", 32'(out_data), 32'h3C);
    in_data[2*W +: W] = 8'h3D;
    out_ready = 1'b1;
    step();
    in_valid = '0;
    step();
    step();

`ifdef STREAM_MUX_PARITY_EN
    mode = MODE_FIXED; sel = 4'd0; in_valid = 16'h0001; in_data = '0;
    in_data[W-1:0] = 8'h07;
    step();
    in_data[W-1:0] = 8'h03;
    #1;
    check_val("parity_07", 32'(out_parity), 32'd1);
    step();
    #1;
    check_val("parity_03", 32'(out_parity), 32'd0);
    in_valid = '0;
    step();
`endif

    // Random traffic, mode and back-pressure.
    for (int i = 0; i < 60; i++) begin
      mode      = 1'($urandom_range(0, 1));
      sel       = 4'($urandom_range(0, 15));
      in_valid  = 16'($urandom) & 16'($urandom);
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    in_valid = '0; out_ready = 1'b1;
    step();
    step();

    // 12-channel instance: load a beat, then an out-of-range Sel.
    d12_mode = MODE_FIXED; d12_sel = 4'd3; d12_in_valid = 12'hFFF; d12_out_ready = 1'b1;
    d12_in_data = '0; d12_in_data[3*W +: W] = 8'h5A;
    @(posedge clk); @(negedge clk); #1;
    check_val("d12_out_valid", 32'(d12_out_valid), 32'd1);
    check_val("d12_out_data", 32'(d12_out_data), 32'h5A);
    check_val("d12_out_chan", 32'(d12_out_chan), 32'd3);
    d12_sel = 4'd13;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_val("d12_bad_ready", 32'(d12_in_ready), 32'd0);
      @(posedge clk); @(negedge clk); #1;
      check_val("d12_sel_err", 32'(d12_sel_err), 32'd1);
      check_val("d12_bad_valid", 32'(d12_out_valid), 32'd0);
    end
    d12_in_valid = '0;
    @(posedge clk); @(negedge clk); #1;
    check_val("d12_sel_err_clr", 32'(d12_sel_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
